// File: rtl/performance_counter_bank.sv
// Memory-mapped bank of wide event counters with sticky overflow, maskable interrupt
// and an atomic low-word/shadow-high-word read scheme for counters wider than 32 bits.
module performance_counter_bank #(
    parameter int          NUM_COUNTERS  = 8,
    parameter int          COUNTER_WIDTH = 48,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_COUNTERS-1:0] perf_events,
    input  logic [31:0]             io_address,
    input  logic                    io_write_en,
    input  logic [31:0]             io_write_data,
    input  logic                    io_read_en,
    output logic [31:0]             io_read_data,
    output logic                    perf_overflow_irq
);

    localparam int          HI_W     = COUNTER_WIDTH - 32;
    localparam logic [31:0] CNT_SPAN = 32'(8 * NUM_COUNTERS);

    logic                     global_en_q, global_en_d;
    logic [NUM_COUNTERS-1:0]  enable_q, enable_d;
    logic [NUM_COUNTERS-1:0]  ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0]  irq_mask_q, irq_mask_d;
    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [HI_W-1:0]          shadow_q, shadow_d;
    logic [31:0]              rd_data_q, rd_data_d;
    logic                     irq_q, irq_d;

    logic [31:0]              offset;
    logic [31:0]              cnt_off;
    logic                     sel_ctrl, sel_enable, sel_ovf, sel_mask, in_cnt;
    logic [NUM_COUNTERS-1:0]  hit_lo, hit_hi;
    logic [NUM_COUNTERS-1:0]  wr_lo, wr_hi, ovf_set, ovf_w1c;
    logic                     clear_all;
    logic [31:0]              rd_value;

    // Each counter owns an 8-byte slot starting at 0x10: low word, then high word.
    always_comb begin
        offset     = io_address - BASE_ADDRESS;
        cnt_off    = offset - 32'h10;
        sel_ctrl   = (offset == 32'h00);
        sel_enable = (offset == 32'h04);
        sel_ovf    = (offset == 32'h08);
        sel_mask   = (offset == 32'h0C);
        in_cnt     = (offset[1:0] == 2'b00) && (offset >= 32'h10) && (cnt_off < CNT_SPAN);
        hit_lo     = '0;
        hit_hi     = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit_lo[i] = in_cnt && !cnt_off[2] && (cnt_off[31:3] == 29'(i));
            hit_hi[i] = in_cnt &&  cnt_off[2] && (cnt_off[31:3] == 29'(i));
        end
    end

    // Read path sees only pre-write state, so a coincident write never leaks into the data.
    always_comb begin
        rd_value = '0;
        shadow_d = shadow_q;
        if (sel_ctrl) begin
            rd_value[0] = global_en_q;
        end
        if (sel_enable) begin
            rd_value[NUM_COUNTERS-1:0] = enable_q;
        end
        if (sel_ovf) begin
            rd_value[NUM_COUNTERS-1:0] = ovf_q;
        end
        if (sel_mask) begin
            rd_value[NUM_COUNTERS-1:0] = irq_mask_q;
        end
        if (|hit_hi) begin
            rd_value[HI_W-1:0] = shadow_q;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (hit_lo[i]) begin
                rd_value = cnt_q[i][31:0];
                if (io_read_en) begin
                    shadow_d = cnt_q[i][COUNTER_WIDTH-1:32];
                end
            end
        end
        rd_data_d = io_read_en ? rd_value : rd_data_q;
    end

    // Per-counter priority: clear-all, then software load, then event increment.
    always_comb begin
        clear_all   = io_write_en && sel_ctrl && io_write_data[1];
        global_en_d = (io_write_en && sel_ctrl)   ? io_write_data[0] : global_en_q;
        enable_d    = (io_write_en && sel_enable) ? io_write_data[NUM_COUNTERS-1:0] : enable_q;
        irq_mask_d  = (io_write_en && sel_mask)   ? io_write_data[NUM_COUNTERS-1:0] : irq_mask_q;
        ovf_w1c     = (io_write_en && sel_ovf)    ? io_write_data[NUM_COUNTERS-1:0] : '0;
        wr_lo       = io_write_en ? hit_lo : '0;
        wr_hi       = io_write_en ? hit_hi : '0;
        ovf_set     = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_all) begin
                cnt_d[i] = '0;
            end else if (wr_lo[i]) begin
                cnt_d[i][31:0] = io_write_data;
            end else if (wr_hi[i]) begin
                cnt_d[i][COUNTER_WIDTH-1:32] = io_write_data[HI_W-1:0];
            end else if (global_en_q && enable_q[i] && perf_events[i]) begin
                cnt_d[i]   = cnt_q[i] + 1'b1;
                ovf_set[i] = &cnt_q[i];
            end
        end
        ovf_d = (ovf_q & ~ovf_w1c) | ovf_set;
        irq_d = |(ovf_d & irq_mask_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            global_en_q <= 1'b0;
            enable_q    <= '0;
            ovf_q       <= '0;
            irq_mask_q  <= '0;
            shadow_q    <= '0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            global_en_q <= global_en_d;
            enable_q    <= enable_d;
            ovf_q       <= ovf_d;
            irq_mask_q  <= irq_mask_d;
            shadow_q    <= shadow_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io_read_data      = rd_data_q;
    assign perf_overflow_irq = irq_q;

endmodule

// File: tb/tb_performance_counter_bank.sv
// Scoreboard bench for performance_counter_bank: expected read data is queued when a
// read is issued and compared when the registered read data appears.
module tb_performance_counter_bank;

    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_EN   = 32'h04;
    localparam logic [31:0] A_OVF  = 32'h08;
    localparam logic [31:0] A_MASK = 32'h0C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  perf_events;
    logic [31:0] io_address;
    logic        io_write_en;
    logic [31:0] io_write_data;
    logic        io_read_en;
    logic [31:0] io_read_data;
    logic        perf_overflow_irq;

    int          tests_run = 0;
    int          fail_cnt  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    performance_counter_bank #(
        .NUM_COUNTERS (8),
        .COUNTER_WIDTH(48),
        .BASE_ADDRESS (32'h0)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .perf_events      (perf_events),
        .io_address       (io_address),
        .io_write_en      (io_write_en),
        .io_write_data    (io_write_data),
        .io_read_en       (io_read_en),
        .io_read_data     (io_read_data),
        .perf_overflow_irq(perf_overflow_irq)
    );

    function automatic logic [31:0] lo_addr(input int i);
        return 32'(16 + 8 * i);
    endfunction

    function automatic logic [31:0] hi_addr(input int i);
        return 32'(20 + 8 * i);
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        io_write_en   = 1'b1;
        io_address    = addr;
        io_write_data = data;
        @(negedge clk);
        io_write_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        io_read_en = 1'b1;
        io_address = addr;
        @(negedge clk);
        io_read_en = 1'b0;
        data       = io_read_data;
    endtask

    task automatic pulse_events(input logic [7:0] mask, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            perf_events = mask;
        end
        @(negedge clk);
        perf_events = '0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        for (int a = 0; a <= 'h54; a += 4) begin
            exp_q.push_back(32'h0);
            bus_read(32'(a), got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL reset_read@%h: got %h expected %h", a, got, exp);
            end
        end
        tests_run++;
        if (perf_overflow_irq !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL reset_irq: got %b expected 0", perf_overflow_irq);
        end
        pulse_events(8'hFF, 4);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h0);
            bus_read(lo_addr(i), got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL pre_enable_lo%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_counting();
        logic [31:0] got, exp;
        logic [31:0] addrs [7] = '{lo_addr(0), lo_addr(1), lo_addr(2), lo_addr(3), A_EN, A_CTRL, A_EN};
        logic [31:0] exps  [7] = '{32'd10, 32'd0, 32'd10, 32'd0, 32'h5, 32'h1, 32'hFF};
        bus_write(A_CTRL, 32'h1);
        bus_write(A_EN, 32'h5);
        pulse_events(8'hFF, 10);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) bus_write(A_EN, 32'hFFFF_FFFF);
            exp_q.push_back(exps[k]);
            bus_read(addrs[k], got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL counting_%0d@%h: got %h expected %h", k, addrs[k], got, exp);
            end
        end
    endtask

    task automatic test_atomic();
        logic [31:0] got, exp;
        logic [31:0] addrs [6] = '{lo_addr(3), hi_addr(3), lo_addr(3), hi_addr(3), lo_addr(3), hi_addr(3)};
        logic [31:0] exps  [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1};
        bus_write(A_EN, 32'h8);
        for (int k = 0; k < 6; k++) begin
            if (k == 0 || k == 2) begin
                bus_write(hi_addr(3), 32'h0);
                bus_write(lo_addr(3), 32'hFFFF_FFFF);
            end
            if (k == 0 || k == 3) pulse_events(8'h08, 1);
            exp_q.push_back(exps[k]);
            bus_read(addrs[k], got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL atomic_%0d@%h: got %h expected %h", k, addrs[k], got, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp;
        logic [31:0] addrs [5] = '{lo_addr(1), hi_addr(1), A_OVF, A_OVF, A_OVF};
        logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h0};
        logic        irq_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus_write(A_EN, 32'h2);
        bus_write(A_MASK, 32'h2);
        bus_write(hi_addr(1), 32'hFFFF);
        bus_write(lo_addr(1), 32'hFFFF_FFFF);
        tests_run++;
        if (perf_overflow_irq !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL irq_before_wrap: got %b expected 0", perf_overflow_irq);
        end
        @(negedge clk);
        perf_events = 8'h02;
        @(negedge clk);
        perf_events = 8'h00;
        tests_run++;
        if (perf_overflow_irq !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL irq_after_wrap: got %b expected 1", perf_overflow_irq);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                bus_write(hi_addr(1), 32'hFFFF);
                bus_write(lo_addr(1), 32'hFFFF_FFFF);
                @(negedge clk);
                perf_events   = 8'h02;
                io_write_en   = 1'b1;
                io_address    = A_OVF;
                io_write_data = 32'h2;
                @(negedge clk);
                perf_events   = 8'h00;
                io_write_en   = 1'b0;
            end
            if (k == 4) bus_write(A_OVF, 32'h2);
            tests_run++;
            if (perf_overflow_irq !== irq_exp[k]) begin
                fail_cnt++;
                $display("[TB] FAIL ovf_irq_%0d: got %b expected %b", k, perf_overflow_irq, irq_exp[k]);
            end
            exp_q.push_back(exps[k]);
            bus_read(addrs[k], got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL overflow_%0d@%h: got %h expected %h", k, addrs[k], got, exp);
            end
        end
    endtask

    task automatic test_priority();
        logic [31:0] got, exp;
        bus_write(A_EN, 32'h1);
        @(negedge clk);
        perf_events   = 8'h01;
        io_write_en   = 1'b1;
        io_address    = lo_addr(0);
        io_write_data = 32'h100;
        @(negedge clk);
        perf_events   = 8'h00;
        io_write_en   = 1'b0;
        exp_q.push_back(32'h100);
        bus_read(lo_addr(0), got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL write_beats_event: got %h expected %h", got, exp);
        end
        bus_write(A_EN, 32'hFF);
        @(negedge clk);
        perf_events   = 8'hFF;
        io_write_en   = 1'b1;
        io_address    = A_CTRL;
        io_write_data = 32'h3;
        @(negedge clk);
        perf_events   = 8'h00;
        io_write_en   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int h = 0; h < 2; h++) begin
                exp_q.push_back(32'h0);
                bus_read((h == 0) ? lo_addr(i) : hi_addr(i), got);
                exp = exp_q.pop_front();
                tests_run++;
                if (got !== exp) begin
                    fail_cnt++;
                    $display("[TB] FAIL clear_all_cnt%0d_%s: got %h expected %h", i, (h == 0) ? "lo" : "hi", got, exp);
                end
            end
        end
        exp_q.push_back(32'h1);
        bus_read(A_CTRL, got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL ctrl_after_clear: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        bus_write(A_EN, 32'h0);
        for (int k = 0; k < 3; k++) bus_write(lo_addr(k), vals[k]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                exp = exp_q.pop_front();
                tests_run++;
                if (io_read_data !== exp) begin
                    fail_cnt++;
                    $display("[TB] FAIL b2b_read_%0d: got %h expected %h", k - 1, io_read_data, exp);
                end
            end
            io_read_en = (k < 3);
            if (k < 3) begin
                io_address = lo_addr(k);
                exp_q.push_back(vals[k]);
            end
        end
        @(negedge clk);
        io_read_en    = 1'b1;
        io_write_en   = 1'b1;
        io_address    = lo_addr(0);
        io_write_data = 32'h99;
        exp_q.push_back(32'h11);
        @(negedge clk);
        io_read_en    = 1'b0;
        io_write_en   = 1'b0;
        exp = exp_q.pop_front();
        tests_run++;
        if (io_read_data !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL rw_same_cycle: got %h expected %h", io_read_data, exp);
        end
        exp_q.push_back(32'h99);
        bus_read(lo_addr(0), got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL rw_after_write: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        logic [31:0] addrs [13] = '{A_CTRL, A_EN, A_OVF, A_MASK, lo_addr(0), lo_addr(1), lo_addr(2),
                                    lo_addr(3), lo_addr(4), lo_addr(5), lo_addr(6), lo_addr(7), hi_addr(7)};
        bus_write(A_CTRL, 32'h1);
        bus_write(A_EN, 32'hFF);
        bus_write(A_MASK, 32'h1);
        bus_write(hi_addr(0), 32'hFFFF);
        bus_write(lo_addr(0), 32'hFFFF_FFFF);
        pulse_events(8'hFF, 3);
        tests_run++;
        if (perf_overflow_irq !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL mid_irq_high: got %b expected 1", perf_overflow_irq);
        end
        exp_q.push_back(32'h25);
        bus_read(lo_addr(1), got);
        exp = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL mid_count_lo1: got %h expected %h", got, exp);
        end
        @(negedge clk);
        perf_events = 8'hFF;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (io_read_data !== 32'h0 || perf_overflow_irq !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL async_reset_outputs: got data %h irq %b expected 0/0", io_read_data, perf_overflow_irq);
        end
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        perf_events = 8'h00;
        pulse_events(8'hFF, 4);
        for (int k = 0; k < 13; k++) begin
            exp_q.push_back(32'h0);
            bus_read(addrs[k], got);
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                fail_cnt++;
                $display("[TB] FAIL post_reset@%h: got %h expected %h", addrs[k], got, exp);
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        perf_events   = '0;
        io_address    = '0;
        io_write_en   = 1'b0;
        io_write_data = '0;
        io_read_en    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_counting();
        test_atomic();
        test_overflow();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
